// File: rtl/williams_blt_bus_responder.sv
// Blitter bus responder: HALT/BA/BS handshake, then blitter read/write/RMW cycles on the memory port.
// Latency 2 clk + memory latency (RMW: one extra memory cycle + 1 clk gap); memory stalls via mem_ready, blitter via blt_ack/en_e_n.
module williams_blt_bus_responder #(
  parameter bit NATIVE_NIBBLE_WE = 1'b0,
  parameter bit BA_BS_QUAL       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_e_n,
  output logic        cpu_halt,
  input  logic        cpu_ba,
  input  logic        cpu_bs,
  input  logic        blt_halt,
  output logic        blt_halt_ack,
  input  logic        blt_rd,
  input  logic        blt_wr,
  input  logic [15:0] blt_address,
  input  logic [7:0]  blt_wdata,
  input  logic [1:0]  blt_nibble_en,
  output logic [7:0]  blt_rdata,
  output logic        blt_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_nibble_we,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    GRANTED   = 3'd2,
    RD        = 3'd3,
    RMW_RD    = 3'd4,
    WR        = 3'd5,
    ACK       = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic        mem_req_q;
  logic        mem_done;
  logic        bus_ok;
  logic        start_mem;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [1:0]  nib_q;
  logic [7:0]  merged;

  assign bus_ok    = cpu_ba && (cpu_bs || !BA_BS_QUAL);
  assign mem_done  = mem_req_q && mem_ready;
  assign start_mem = (state == GRANTED) &&
                     (state_nxt == RD || state_nxt == RMW_RD || state_nxt == WR);
  assign merged    = {nib_q[1] ? wdata_q[7:4] : mem_rdata[7:4],
                      nib_q[0] ? wdata_q[3:0] : mem_rdata[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (blt_halt) state_nxt = HALT_WAIT;
      HALT_WAIT: begin
        if (!blt_halt)             state_nxt = IDLE;
        else if (en_e_n && bus_ok) state_nxt = GRANTED;
      end
      GRANTED: begin
        if (!blt_halt)    state_nxt = IDLE;
        else if (blt_rd)  state_nxt = RD;
        else if (blt_wr) begin
          if (blt_nibble_en == 2'b00)                            state_nxt = ACK;
          else if (blt_nibble_en == 2'b11 || NATIVE_NIBBLE_WE)   state_nxt = WR;
          else                                                   state_nxt = RMW_RD;
        end
      end
      // A dropped request still lets the memory cycle (and the RMW write-back) finish.
      RD:      if (mem_done) state_nxt = blt_halt ? ACK : IDLE;
      RMW_RD:  if (mem_done) state_nxt = WR;
      WR:      if (mem_done) state_nxt = blt_halt ? ACK : IDLE;
      ACK:     if (en_e_n)   state_nxt = GRANTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      nib_q     <= 2'b00;
      blt_rdata <= 8'h00;
    end else begin
      if (start_mem) begin
        addr_q    <= blt_address;
        wdata_q   <= blt_wdata;
        nib_q     <= blt_nibble_en;
        mem_req_q <= 1'b1;
      end else if (mem_done) begin
        mem_req_q <= 1'b0;
      end else if (state == WR) begin
        // Re-raises the request after the one-clock gap following the RMW read.
        mem_req_q <= 1'b1;
      end
      if (state == RD && mem_done)     blt_rdata <= mem_rdata;
      if (state == RMW_RD && mem_done) wdata_q   <= merged;
    end
  end

  always_comb begin
    cpu_halt      = (state != IDLE);
    blt_halt_ack  = (state != IDLE) && (state != HALT_WAIT);
    blt_ack       = (state == ACK);
    mem_req       = mem_req_q;
    mem_we        = (state == WR);
    mem_nibble_we = 2'b00;
    if (state == WR) mem_nibble_we = NATIVE_NIBBLE_WE ? nib_q : 2'b11;
    mem_address   = addr_q;
    mem_wdata     = wdata_q;
  end

endmodule
